keypad_scanner: RTL and testbench

Scanning input driver for a 4x4 matrix keypad on a Pmod header (Digilent PmodKYPD layout). It walks an active-low column strobe across the keypad, samples the synchronised active-low row lines, debounces over whole scan frames and reports each debounced key press as a hex code with a one-cycle valid pulse. It sits beside the seven-segment driver on the 100 MHz fabric clock, and its KeyCode output is suitable for direct display as one BCD/hex digit.

---
 rtl/keypad_scanner_pkg.sv | 37 +++
 rtl/keypad_scanner_if.sv | 26 ++
 rtl/keypad_key_decoder.sv | 40 ++++
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scanner_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StPressed,
    StReleaseWait
  } state_e;

  // Per-column / per-frame key count class
  typedef enum logic [1:0] {
    FrNone,
    FrSingle,
    FrMulti
  } frame_res_e;

  // Key code indexed by {row, col}
  localparam logic [3:0] KeyMap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Column strobe after reset: col0 driven low
  localparam logic [3:0] ColumnsReset = 4'hE;

  // Combine two partial results: any two keys anywhere make the frame MULTI
  function automatic frame_res_e merge_res(frame_res_e a, frame_res_e b);
    if (a == FrNone) return b;
    if (b == FrNone) return a;
    return FrMulti;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and result signals of the keypad scanner.
interface keypad_scanner_if;
  logic [3:0] Rows;
  logic [3:0] Columns;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyHeld;

  // Scanner side
  modport master (
    input  Rows,
    output Columns,
    output KeyCode,
    output KeyValid,
    output KeyHeld
  );

  // Keypad / consumer side
  modport slave (
    output Rows,
    input  Columns,
    input  KeyCode,
    input  KeyValid,
    input  KeyHeld
  );
endinterface

// File: rtl/keypad_key_decoder.sv
// Maps the active column strobe and active-low rows to a key class, a code and a key mask.
module keypad_key_decoder
  import keypad_scanner_pkg::*;
(
  input  logic [3:0]  columns,
  input  logic [3:0]  rows,
  output frame_res_e  res,
  output logic [3:0]  code,
  output logic [15:0] mask
);

  logic [1:0] col;
  logic [2:0] hits;

  // Decode column index, then collect every pressed row in that column
  always_comb begin
    col  = 2'd0;
    hits = 3'd0;
    code = 4'h0;
    mask = 16'h0000;
    unique case (columns)
      4'hE:    col = 2'd0;
      4'hD:    col = 2'd1;
      4'hB:    col = 2'd2;
      4'h7:    col = 2'd3;
      default: col = 2'd0;
    endcase
    for (int r = 0; r < 4; r++) begin
      if (!rows[r]) begin
        hits = hits + 3'd1;
        code = KeyMap[{2'(r), col}];
        mask[KeyMap[{2'(r), col}]] = 1'b1;
      end
    end
    if (hits == 3'd0)      res = FrNone;
    else if (hits == 3'd1) res = FrSingle;
    else                   res = FrMulti;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row synchroniser, frame accumulator and debounce FSM.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV_BITS   = 17,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input logic               Clk,
  input logic               Reset,
  keypad_scanner_if.master  bus
);

  localparam logic [SCAN_DIV_BITS-1:0] DwellOne  = 1;
  localparam logic [3:0]               DebFrames = 4'(DEBOUNCE_FRAMES);

  logic [3:0]               rows_meta_q, rows_sync_q;
  logic [SCAN_DIV_BITS-1:0] dwell_q;
  logic [3:0]               columns_q;
  frame_res_e               acc_res_q;
  logic [3:0]               acc_code_q;
  logic [15:0]              acc_mask_q;

  frame_res_e  col_res, frame_res;
  logic [3:0]  col_code, frame_code;
  logic [15:0] col_mask, frame_mask;
  logic        sample, frame_end;

  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] fc_q, fc_d, fc_inc;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;

  keypad_key_decoder u_decoder (
    .columns (columns_q),
    .rows    (rows_sync_q),
    .res     (col_res),
    .code    (col_code),
    .mask    (col_mask)
  );

  assign sample     = &dwell_q;
  assign frame_end  = sample && (columns_q == 4'h7);
  assign frame_res  = merge_res(acc_res_q, col_res);
  assign frame_code = (acc_res_q == FrNone) ? col_code : acc_code_q;
  assign frame_mask = acc_mask_q | col_mask;

  // Row synchroniser, dwell counter, column rotation and per-frame accumulation
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
      dwell_q     <= '0;
      columns_q   <= ColumnsReset;
      acc_res_q   <= FrNone;
      acc_code_q  <= 4'h0;
      acc_mask_q  <= 16'h0000;
    end else begin
      rows_meta_q <= bus.Rows;
      rows_sync_q <= rows_meta_q;
      dwell_q     <= dwell_q + DwellOne;
      if (sample) begin
        columns_q <= {columns_q[2:0], columns_q[3]};
        if (frame_end) begin
          acc_res_q  <= FrNone;
          acc_code_q <= 4'h0;
          acc_mask_q <= 16'h0000;
        end else begin
          acc_res_q  <= frame_res;
          acc_code_q <= frame_code;
          acc_mask_q <= frame_mask;
        end
      end
    end
  end

  // Debounce FSM state and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cand_q  <= 4'h0;
      fc_q    <= 4'h0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      fc_q    <= fc_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Debounce FSM next state, evaluated only on the frame-end sample
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    fc_d    = fc_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    fc_inc  = (fc_q >= DebFrames) ? DebFrames : fc_q + 4'd1;
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (frame_res == FrSingle) begin
            cand_d = frame_code;
            if (DebFrames == 4'd1) begin
              code_d  = frame_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              fc_d    = 4'h0;
              state_d = StPressed;
            end else begin
              fc_d    = 4'd1;
              state_d = StPressDb;
            end
          end
        end
        StPressDb: begin
          if (frame_res == FrSingle && frame_code == cand_q) begin
            fc_d = fc_inc;
            if (fc_inc == DebFrames) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              fc_d    = 4'h0;
              state_d = StPressed;
            end
          end else if (frame_res == FrSingle) begin
            cand_d = frame_code;
            fc_d   = 4'd1;
          end else begin
            fc_d    = 4'h0;
            state_d = StIdle;
          end
        end
        StPressed: begin
          // Any frame still showing the accepted key, even alongside others, keeps it held
          if (frame_mask[cand_q]) begin
            fc_d = 4'h0;
          end else begin
            fc_d = fc_inc;
            if (fc_inc == DebFrames) begin
              held_d  = 1'b0;
              fc_d    = 4'h0;
              state_d = StReleaseWait;
            end
          end
        end
        StReleaseWait: begin
          // Discard this frame so the next key always gets a full debounce
          fc_d    = 4'h0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.Columns  = columns_q;
  assign bus.KeyCode  = code_q;
  assign bus.KeyValid = valid_q;
  assign bus.KeyHeld  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad model, step table and reset corner cases.
module tb_keypad_scanner;

  localparam int FrameCycles = 16;

  // Bench's own key map, indexed by row*4+col
  localparam logic [3:0] TbMap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD
  };
  localparam logic [3:0] ColSeq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  typedef struct {
    logic [15:0] keys;        // bit k set = key with code k held
    int          frames;
    int          pulse_frame; // 0 = no pulse expected
    logic [3:0]  code;
    logic        held;
  } step_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] keys = 16'h0000;
  logic [3:0]  rows_drv;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pulses = 0;
  int last_pulse_edge = 0;
  logic [3:0] pulse_code = 4'h0;
  logic activity;
  step_t steps [22];

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV_BITS   (2),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Keypad model: a held key pulls its row low while its column is strobed
  always_comb begin
    rows_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (bus.Columns[c] == 1'b0 && keys[TbMap[r*4+c]]) rows_drv[r] = 1'b0;
  end
  assign bus.Rows = rows_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    edge_n++;
    if (bus.KeyValid) begin
      pulses++;
      last_pulse_edge = edge_n;
      pulse_code = bus.KeyCode;
    end
  endtask

  initial begin
    steps[0]  = '{16'h0020, 3, 3, 4'h5, 1'b1};  // '5' accepted
    steps[1]  = '{16'h0020, 1, 0, 4'h5, 1'b1};
    steps[2]  = '{16'h0000, 2, 0, 4'h5, 1'b1};  // two empty frames: still held
    steps[3]  = '{16'h0000, 1, 0, 4'h5, 1'b0};  // third empty frame: released
    steps[4]  = '{16'h0000, 1, 0, 4'h5, 1'b0};
    steps[5]  = '{16'h0200, 2, 0, 4'h5, 1'b0};  // '9' bounce
    steps[6]  = '{16'h0000, 1, 0, 4'h5, 1'b0};
    steps[7]  = '{16'h0200, 3, 3, 4'h9, 1'b1};
    steps[8]  = '{16'h0000, 3, 0, 4'h9, 1'b0};
    steps[9]  = '{16'h0000, 1, 0, 4'h9, 1'b0};
    steps[10] = '{16'h0006, 10, 0, 4'h9, 1'b0}; // '1'+'2' together
    steps[11] = '{16'h0002, 3, 3, 4'h1, 1'b1};  // '2' released
    steps[12] = '{16'h0006, 4, 0, 4'h1, 1'b1};  // multi containing cand keeps held
    steps[13] = '{16'h000C, 3, 0, 4'h1, 1'b0};  // multi without cand releases
    steps[14] = '{16'h0004, 1, 0, 4'h1, 1'b0};  // frame ignored after release
    steps[15] = '{16'h0004, 3, 3, 4'h2, 1'b1};
    steps[16] = '{16'h0000, 4, 0, 4'h2, 1'b0};
    steps[17] = '{16'h0400, 1, 0, 4'h2, 1'b0};  // 'A' candidate
    steps[18] = '{16'h0800, 2, 0, 4'h2, 1'b0};  // 'B' restarts the count
    steps[19] = '{16'h0800, 1, 1, 4'hB, 1'b1};
    steps[20] = '{16'h0000, 4, 0, 4'hB, 1'b0};
    steps[21] = '{16'h2000, 3, 3, 4'hD, 1'b1};  // 'D' held into reset test

    // Reset state
    repeat (3) begin
      @(posedge Clk);
      #1;
      check("reset_columns", bus.Columns, 4'hE);
      check("reset_keycode", bus.KeyCode, 4'h0);
      check("reset_valid", bus.KeyValid, 1'b0);
      check("reset_held", bus.KeyHeld, 1'b0);
    end
    Reset = 1'b0;

    // Idle scan: column rotation, no key activity
    activity = 1'b0;
    for (int n = 1; n <= 2 * FrameCycles; n++) begin
      tick();
      check($sformatf("columns_edge%0d", n), bus.Columns, ColSeq[(n / 4) % 4]);
      activity = activity | bus.KeyValid | bus.KeyHeld;
    end
    check("idle_activity", activity, 1'b0);
    check("idle_keycode", bus.KeyCode, 4'h0);

    // Table-driven frame-aligned steps
    for (int s = 0; s < 22; s++) begin
      int base;
      keys   = steps[s].keys;
      pulses = 0;
      base   = edge_n;
      repeat (steps[s].frames * FrameCycles) tick();
      check($sformatf("step%0d_pulses", s), pulses, (steps[s].pulse_frame != 0) ? 1 : 0);
      if (steps[s].pulse_frame != 0 && pulses != 0) begin
        check($sformatf("step%0d_pulse_edge", s), last_pulse_edge - base,
              steps[s].pulse_frame * FrameCycles);
        check($sformatf("step%0d_pulse_code", s), pulse_code, steps[s].code);
      end
      check($sformatf("step%0d_keycode", s), bus.KeyCode, steps[s].code);
      check($sformatf("step%0d_held", s), bus.KeyHeld, steps[s].held);
    end

    // One-cycle reset mid-frame while 'D' is pressed and held
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midreset_held", bus.KeyHeld, 1'b0);
    check("midreset_keycode", bus.KeyCode, 4'h0);
    check("midreset_columns", bus.Columns, 4'hE);

    // Reset landing on the edge that would accept the press wins
    edge_n = 0;
    pulses = 0;
    repeat (3 * FrameCycles - 1) tick();
    check("prereset_pulses", pulses, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("reset_blocks_valid", bus.KeyValid, 1'b0);
    check("reset_blocks_held", bus.KeyHeld, 1'b0);

    // Still-held key is re-debounced from scratch
    edge_n = 0;
    pulses = 0;
    repeat (3 * FrameCycles + 2) tick();
    check("redebounce_pulses", pulses, 1);
    check("redebounce_edge", last_pulse_edge, 3 * FrameCycles);
    check("redebounce_code", pulse_code, 4'hD);
    check("redebounce_held", bus.KeyHeld, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
